// File: rtl/digit_scan_ctrl.sv
// ============================================================================
// digit_scan_ctrl : time-multiplexed digit scanner for a 2-to-4 decoder.
//                   Holds each enabled position for a dwell time, blanks
//                   between positions and skips masked positions.
// Revision 1.0
// ============================================================================
`default_nettype none

module digit_scan_ctrl #(
   parameter int CNT_W = 16,
   parameter int DWELL = 1000,
   parameter int BLANK = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic [3:0] digit_mask,
   output logic [1:0] sel,
   output logic       sel_en,
   output logic       frame_pulse,
   output logic       busy
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACTIVE = 2'd1;
   localparam logic [1:0] S_BLANK  = 2'd2;

   localparam logic [CNT_W-1:0] c_dwell_ld = CNT_W'(DWELL - 1);
   localparam logic [CNT_W-1:0] c_blank_ld = (BLANK > 0) ? CNT_W'(BLANK - 1) : '0;

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_cnt;

   logic [1:0]       w_state;
   logic [1:0]       w_sel;
   logic [CNT_W-1:0] w_cnt;
   logic             w_frame;
   logic             w_adv;
   logic [1:0]       w_next_idx;

   function automatic logic [1:0] f_lowest(input logic [3:0] m);
      logic [1:0] r;
      r = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         if (m[k]) r = 2'(k);
      end
      return r;
   endfunction

   // Search order sel+1, sel+2, sel+3, sel; the nearest hit wins.
   function automatic logic [1:0] f_next(input logic [1:0] cur, input logic [3:0] m);
      logic [1:0] r;
      logic [1:0] idx;
      r = cur;
      for (int k = 4; k >= 1; k--) begin
         idx = cur + 2'(k);
         if (m[idx]) r = idx;
      end
      return r;
   endfunction

   assign w_next_idx = f_next(sel, digit_mask);

   always_comb begin
      w_state = r_state;
      w_sel   = sel;
      w_cnt   = r_cnt;
      w_frame = 1'b0;
      w_adv   = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (run && (digit_mask != 4'd0)) begin
               w_state = S_ACTIVE;
               w_sel   = f_lowest(digit_mask);
               w_cnt   = c_dwell_ld;
            end
         end
         S_ACTIVE: begin
            if (!run) begin
               w_state = S_IDLE;
               w_cnt   = '0;
            end else if (!digit_mask[sel] || (r_cnt == '0)) begin
               if (BLANK > 0) begin
                  w_state = S_BLANK;
                  w_cnt   = c_blank_ld;
               end else begin
                  w_adv = 1'b1;
               end
            end else begin
               w_cnt = r_cnt - CNT_W'(1);
            end
         end
         S_BLANK: begin
            if (!run) begin
               w_state = S_IDLE;
               w_cnt   = '0;
            end else if (r_cnt == '0) begin
               w_adv = 1'b1;
            end else begin
               w_cnt = r_cnt - CNT_W'(1);
            end
         end
         default: begin
            w_state = S_IDLE;
            w_cnt   = '0;
         end
      endcase

      if (w_adv) begin
         if (digit_mask == 4'd0) begin
            w_state = S_IDLE;
            w_cnt   = '0;
         end else begin
            w_state = S_ACTIVE;
            w_sel   = w_next_idx;
            w_cnt   = c_dwell_ld;
            w_frame = (w_next_idx <= sel);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         sel         <= 2'd0;
         sel_en      <= 1'b0;
         frame_pulse <= 1'b0;
         busy        <= 1'b0;
      end else begin
         r_state     <= w_state;
         r_cnt       <= w_cnt;
         sel         <= w_sel;
         sel_en      <= (w_state == S_ACTIVE);
         frame_pulse <= w_frame;
         busy        <= (w_state != S_IDLE);
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_digit_scan_ctrl.sv
// ============================================================================
// tb_digit_scan_ctrl : checks two scanner instances (BLANK=2 and BLANK=0)
//                      against a phase/age reference model.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_digit_scan_ctrl;

   localparam int DW = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       run = 1'b0;
   logic [3:0] digit_mask = 4'd0;

   logic [1:0] sel_a, sel_b;
   logic       en_a, en_b, fp_a, fp_b, bz_a, bz_b;

   int n_checks = 0;
   int n_errors = 0;

   // Model state per instance: mode 0=idle 1=on 2=off, age = cycles spent in phase.
   int m_mode [2] = '{0, 0};
   int m_age  [2] = '{0, 0};
   int m_sel  [2] = '{0, 0};
   int m_frame[2] = '{0, 0};

   digit_scan_ctrl #(.CNT_W(16), .DWELL(DW), .BLANK(2)) dut_a (
      .clk(clk), .rst(rst), .run(run), .digit_mask(digit_mask),
      .sel(sel_a), .sel_en(en_a), .frame_pulse(fp_a), .busy(bz_a));

   digit_scan_ctrl #(.CNT_W(16), .DWELL(DW), .BLANK(0)) dut_b (
      .clk(clk), .rst(rst), .run(run), .digit_mask(digit_mask),
      .sel(sel_b), .sel_en(en_b), .frame_pulse(fp_b), .busy(bz_b));

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: actual=%0d expected=%0d", name, $time, act, exp);
      end
   endtask

   function automatic int lowest(input logic [3:0] m);
      for (int k = 0; k < 4; k++) if (m[k]) return k;
      return 0;
   endfunction

   task automatic advance(input int i);
      int nxt;
      if (digit_mask == 4'd0) begin
         m_mode[i] = 0;
         m_age[i]  = 0;
      end else begin
         nxt = m_sel[i];
         for (int k = 4; k >= 1; k--) if (digit_mask[(m_sel[i] + k) % 4]) nxt = (m_sel[i] + k) % 4;
         m_frame[i] = (nxt <= m_sel[i]) ? 1 : 0;
         m_sel[i]   = nxt;
         m_mode[i]  = 1;
         m_age[i]   = 0;
      end
   endtask

   task automatic model_step(input int i, input int blank);
      m_frame[i] = 0;
      if (m_mode[i] == 0) begin
         if (run && digit_mask != 4'd0) begin
            m_mode[i] = 1;
            m_sel[i]  = lowest(digit_mask);
            m_age[i]  = 0;
         end
      end else if (!run) begin
         m_mode[i] = 0;
         m_age[i]  = 0;
      end else if (m_mode[i] == 1) begin
         if (!digit_mask[m_sel[i]] || m_age[i] == DW - 1) begin
            if (blank > 0) begin
               m_mode[i] = 2;
               m_age[i]  = 0;
            end else begin
               advance(i);
            end
         end else begin
            m_age[i]++;
         end
      end else begin
         if (m_age[i] == blank - 1) advance(i);
         else m_age[i]++;
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0; m_age[i] = 0; m_sel[i] = 0; m_frame[i] = 0;
         end
      end else begin
         model_step(0, 2);
         model_step(1, 0);
      end
   end

   always @(negedge clk) begin
      chk("cmp_sel_a",   sel_a, m_sel[0]);
      chk("cmp_en_a",    en_a,  (m_mode[0] == 1) ? 1 : 0);
      chk("cmp_frame_a", fp_a,  m_frame[0]);
      chk("cmp_busy_a",  bz_a,  (m_mode[0] != 0) ? 1 : 0);
      chk("cmp_sel_b",   sel_b, m_sel[1]);
      chk("cmp_en_b",    en_b,  (m_mode[1] == 1) ? 1 : 0);
      chk("cmp_frame_b", fp_b,  m_frame[1]);
      chk("cmp_busy_b",  bz_b,  (m_mode[1] != 0) ? 1 : 0);
   end

   // Called at a negedge; returns at the negedge right after entry into ACTIVE.
   task automatic restart(input logic [3:0] m);
      run = 1'b0;
      @(negedge clk);
      digit_mask = m;
      run = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_sel", sel_a, 0);
      chk("rst_en", en_a, 0);
      chk("rst_frame", fp_a, 0);
      chk("rst_busy", bz_a, 0);
      rst = 1'b0;
      @(negedge clk);

      restart(4'b1111);
      for (int c = 0; c < 48; c++) begin
         chk("scan_en",    en_a, ((c % 6) < 4) ? 1 : 0);
         chk("scan_sel",   sel_a, (c / 6) % 4);
         chk("scan_frame", fp_a, (c > 0 && c % 24 == 0) ? 1 : 0);
         chk("nb_en",      en_b, 1);
         chk("nb_sel",     sel_b, (c / 4) % 4);
         chk("nb_frame",   fp_b, (c > 0 && c % 16 == 0) ? 1 : 0);
         @(negedge clk);
      end

      restart(4'b1010);
      for (int c = 0; c < 36; c++) begin
         chk("skip_sel",   sel_a, ((c / 6) % 2) ? 3 : 1);
         chk("skip_frame", fp_a, (c > 0 && c % 12 == 0) ? 1 : 0);
         chk("skip_sel_b", sel_b, ((c / 4) % 2) ? 3 : 1);
         chk("skip_frm_b", fp_b, (c > 0 && c % 8 == 0) ? 1 : 0);
         @(negedge clk);
      end

      restart(4'b0100);
      for (int c = 0; c < 24; c++) begin
         chk("one_sel",    sel_a, 2);
         chk("one_en",     en_a, ((c % 6) < 4) ? 1 : 0);
         chk("one_frame",  fp_a, (c > 0 && c % 6 == 0) ? 1 : 0);
         chk("one_frm_b",  fp_b, (c > 0 && c % 4 == 0) ? 1 : 0);
         @(negedge clk);
      end

      restart(4'b1111);
      repeat (13) @(negedge clk);
      chk("stop_pre_sel", sel_a, 2);
      run = 1'b0;
      @(negedge clk);
      chk("stop_en", en_a, 0);
      chk("stop_busy", bz_a, 0);
      chk("stop_sel", sel_a, 2);
      chk("stop_frame", fp_a, 0);

      digit_mask = 4'd0;
      run = 1'b1;
      repeat (5) @(negedge clk);
      chk("mask0_busy", bz_a, 0);
      chk("mask0_en", en_a, 0);
      chk("mask0_busy_b", bz_b, 0);

      restart(4'b1111);
      @(negedge clk);
      digit_mask = 4'b1110;
      @(negedge clk);
      chk("clr_en", en_a, 0);
      chk("clr_busy", bz_a, 1);
      chk("clr_sel_b", sel_b, 1);
      repeat (2) @(negedge clk);
      chk("clr_resume_en", en_a, 1);
      chk("clr_resume_sel", sel_a, 1);

      restart(4'b1111);
      repeat (10) @(negedge clk);
      chk("arst_pre_en", en_a, 0);
      chk("arst_pre_sel", sel_a, 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_sel", sel_a, 0);
      chk("arst_en", en_a, 0);
      chk("arst_busy", bz_a, 0);
      chk("arst_frame", fp_a, 0);
      digit_mask = 4'b1100;
      #1 rst = 1'b0;
      @(negedge clk);
      chk("arst_resume_en", en_a, 1);
      chk("arst_resume_sel", sel_a, 2);

      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 399) == 0) begin
            #2 rst = 1'b1;
            #2 rst = 1'b0;
         end
         if ($urandom_range(0, 39) == 0) run = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 29) == 0) digit_mask = 4'($urandom_range(0, 15));
         @(negedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
